// File: rtl/refill_pkg.sv
// rtl/refill_pkg.sv - shared types and constants for the cache-line refill master
//
// Holds the refill FSM state encoding, the AXI transfer-size code for one
// 32-bit word, and the default number of words per cache line.

package refill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } refill_state_t;

    // AXI arsize encoding for 4-byte beats
    localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

    localparam int DEFAULT_LINE_WORDS = 8;

endpackage : refill_pkg

// File: rtl/refill_line_buf.sv
// rtl/refill_line_buf.sv - cache-line assembly buffer written one word per beat
//
// Ports:
//   aclk     - clock
//   wr_en    - write wr_data into word wr_idx on this edge
//   wr_idx   - word index within the line
//   wr_data  - 32-bit word to store
//   line     - whole line, word 0 in bits [31:0]
//
// The storage is deliberately not reset: line contents are only meaningful
// once a refill has completed.

module refill_line_buf #(
    parameter int WORDS = 8,
    parameter int IDX_W = 3
) (
    input  logic                  aclk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [31:0]           wr_data,
    output logic [32*WORDS-1:0]   line
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    for (genvar i = 0; i < WORDS; i++) begin : g_flat
        assign line[32*i +: 32] = mem[i];
    end

endmodule : refill_line_buf

// File: rtl/axi_refill_master.sv
// rtl/axi_refill_master.sv - AXI read master fetching one aligned cache line per miss
//
// Optional feature macro: REFILL_EARLY_WORD_EN (critical-word early forward).
//
// Ports:
//   aclk, aresetn                 - clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr  - miss request handshake and byte address
//   resp_valid/resp_ready         - refilled line handshake
//   resp_line                     - assembled line, word 0 in bits [31:0]
//   resp_err                      - rlast disagreed with the beat count this refill
//   early_valid/early_data        - one-cycle forward of the missed word
//   m_axi_ar*                     - AXI read address channel (single INCR burst)
//   m_axi_r*                      - AXI read data channel

module axi_refill_master
    import refill_pkg::*;
#(
    parameter int         LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter logic [3:0] ARID       = 4'd0
) (
    input  logic                     aclk,
    input  logic                     aresetn,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,

    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [32*LINE_WORDS-1:0] resp_line,
    output logic                     resp_err,

    output logic                     early_valid,
    output logic [31:0]              early_data,

    output logic [3:0]               m_axi_arid,
    output logic [31:0]              m_axi_araddr,
    output logic [3:0]               m_axi_arlen,
    output logic [2:0]               m_axi_arsize,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,

    input  logic [31:0]              m_axi_rdata,
    input  logic                     m_axi_rlast,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);

    localparam int               IDX_W     = $clog2(LINE_WORDS);
    localparam int               OFF_W     = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    refill_state_t    state;
    logic [IDX_W-1:0] beat_cnt;
    logic [31:0]      araddr_q;
    logic             req_fire;
    logic             beat_fire;

    assign req_fire  = req_valid && req_ready;
    assign beat_fire = (state == ST_DATA) && m_axi_rvalid && m_axi_rready;

    assign m_axi_arid   = ARID;
    assign m_axi_araddr = araddr_q;
    assign m_axi_arlen  = 4'(LINE_WORDS - 1);
    assign m_axi_arsize = AXI_SIZE_WORD;

    // Handshake outputs are registered alongside the state so each is high
    // in exactly one state and nothing combinational reaches the ports.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            beat_cnt      <= '0;
            araddr_q      <= '0;
            resp_err      <= 1'b0;
            req_ready     <= 1'b1;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            resp_valid    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        araddr_q      <= {req_addr[31:OFF_W], {OFF_W{1'b0}}};
                        resp_err      <= 1'b0;
                        req_ready     <= 1'b0;
                        m_axi_arvalid <= 1'b1;
                        state         <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        beat_cnt      <= '0;
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        // Completion follows our own beat count; rlast only
                        // feeds the error flag.
                        if (beat_cnt == LAST_BEAT) begin
                            if (!m_axi_rlast) begin
                                resp_err <= 1'b1;
                            end
                            m_axi_rready <= 1'b0;
                            resp_valid   <= 1'b1;
                            state        <= ST_DONE;
                        end else if (m_axi_rlast) begin
                            resp_err <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // req_ready only rises on the following edge, so a new
                    // request cannot slip in during the response handshake.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    refill_line_buf #(
        .WORDS (LINE_WORDS),
        .IDX_W (IDX_W)
    ) u_line_buf (
        .aclk    (aclk),
        .wr_en   (beat_fire),
        .wr_idx  (beat_cnt),
        .wr_data (m_axi_rdata),
        .line    (resp_line)
    );

`ifdef REFILL_EARLY_WORD_EN
    logic [IDX_W-1:0] crit_idx;
    logic             early_valid_q;
    logic [31:0]      early_data_q;
    logic             crit_hit;

    assign crit_hit = beat_fire && (beat_cnt == crit_idx);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            crit_idx      <= '0;
            early_valid_q <= 1'b0;
            early_data_q  <= '0;
        end else begin
            if (req_fire) begin
                crit_idx <= req_addr[OFF_W-1:2];
            end
            early_valid_q <= crit_hit;
            if (crit_hit) begin
                early_data_q <= m_axi_rdata;
            end
        end
    end

    assign early_valid = early_valid_q;
    assign early_data  = early_data_q;
`else
    assign early_valid = 1'b0;
    assign early_data  = 32'd0;
`endif

    // Byte offset bits never reach the bus; collected here so they are
    // visibly consumed in every build.
    logic unused_req_bits;
    assign unused_req_bits = &{1'b0, req_addr[OFF_W-1:0]};

endmodule : axi_refill_master

// File: tb/tb_axi_refill_master.sv
// tb/tb_axi_refill_master.sv - directed self-checking bench for axi_refill_master

module tb_axi_refill_master;

    localparam int LW = 8;

    logic            aclk;
    logic            aresetn;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic            resp_valid;
    logic            resp_ready;
    logic [32*LW-1:0] resp_line;
    logic            resp_err;
    logic            early_valid;
    logic [31:0]     early_data;
    logic [3:0]      m_axi_arid;
    logic [31:0]     m_axi_araddr;
    logic [3:0]      m_axi_arlen;
    logic [2:0]      m_axi_arsize;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [31:0]     m_axi_rdata;
    logic            m_axi_rlast;
    logic            m_axi_rvalid;
    logic            m_axi_rready;

    int checks = 0;
    int errors = 0;
    int early_pulses;
    logic [31:0] early_seen;

    axi_refill_master #(
        .LINE_WORDS (LW),
        .ARID       (4'd0)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_line     (resp_line),
        .resp_err      (resp_err),
        .early_valid   (early_valid),
        .early_data    (early_data),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [32*LW-1:0] mk_line(input logic [31:0] base);
        logic [32*LW-1:0] l;
        for (int i = 0; i < LW; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic sample_early();
        if (early_valid === 1'b1) begin
            early_pulses++;
            early_seen = early_data;
        end
    endtask

    // Presents a request, then answers AR immediately; returns at the
    // negedge where the DUT should be in DATA.
    task automatic start_refill(input logic [31:0] addr);
        req_addr  = addr;
        req_valid = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        m_axi_arready = 1'b1;
        @(negedge aclk);
        m_axi_arready = 1'b0;
    endtask

    // Drives LW beats; gap idle cycles between beats; rlast on index rlast_at.
    task automatic drive_beats(input logic [31:0] base, input int gap, input int rlast_at);
        for (int i = 0; i < LW; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = base + 32'(i);
            m_axi_rlast  = (i == rlast_at);
            @(negedge aclk);
            sample_early();
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
            if (i != LW - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge aclk);
                    sample_early();
                end
            end
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(negedge aclk);
        sample_early();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        @(negedge aclk);
        checks++;
        if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || resp_valid !== 1'b0 ||
            early_valid !== 1'b0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: arvalid=%b rready=%b resp_valid=%b early_valid=%b resp_err=%b, required all 0",
                     m_axi_arvalid, m_axi_rready, resp_valid, early_valid, resp_err);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_basic();
        // stray R beat in IDLE must not be accepted
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'hDEAD_BEEF;
        @(negedge aclk);
        checks++;
        if (m_axi_rready !== 1'b0) begin
            errors++;
            $display("FAIL idle_rready: got %b, required 0", m_axi_rready);
        end
        m_axi_rvalid = 1'b0;

        req_addr  = 32'h1000_0014;
        req_valid = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        checks++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h1000_0000 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ar: arvalid=%b araddr=%h req_ready=%b, required 1 10000000 0",
                     m_axi_arvalid, m_axi_araddr, req_ready);
        end
        checks++;
        if (m_axi_arlen !== 4'd7 || m_axi_arsize !== 3'b010 || m_axi_arid !== 4'd0) begin
            errors++;
            $display("FAIL basic_ar_attr: arlen=%0d arsize=%b arid=%0d, required 7 010 0",
                     m_axi_arlen, m_axi_arsize, m_axi_arid);
        end
        m_axi_arready = 1'b1;
        @(negedge aclk);
        m_axi_arready = 1'b0;
        checks++;
        if (m_axi_rready !== 1'b1 || m_axi_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_data_state: rready=%b arvalid=%b, required 1 0", m_axi_rready, m_axi_arvalid);
        end
        drive_beats(32'h0000_00A0, 0, 7);
        checks++;
        if (resp_valid !== 1'b1 || resp_line !== mk_line(32'h0000_00A0) || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_resp: valid=%b err=%b line=%h, required 1 0 %h",
                     resp_valid, resp_err, resp_line, mk_line(32'h0000_00A0));
        end
        checks++;
        if (m_axi_rready !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_ready: rready=%b req_ready=%b, required 0 0", m_axi_rready, req_ready);
        end
        finish_resp();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: resp_valid=%b req_ready=%b, required 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        int hv = 0;
        req_addr  = 32'h0800_0044;
        req_valid = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h0800_0040) unstable++;
            @(negedge aclk);
        end
        m_axi_arready = 1'b1;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h0800_0040) unstable++;
        @(negedge aclk);
        m_axi_arready = 1'b0;
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL bp_ar_stable: %0d unstable cycles, required 0", unstable);
        end
        drive_beats(32'h5500_0010, 1, 7);
        for (int k = 0; k < 4; k++) begin
            if (resp_valid === 1'b1) hv++;
            if (k == 3) resp_ready = 1'b1;
            @(negedge aclk);
        end
        resp_ready = 1'b0;
        checks++;
        if (hv !== 4 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_resp_hold: held %0d cycles, valid after=%b, required 4 0", hv, resp_valid);
        end
        checks++;
        if (resp_line !== mk_line(32'h5500_0010) || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_line: line=%h err=%b, required %h 0", resp_line, resp_err, mk_line(32'h5500_0010));
        end
    endtask

    task automatic test_early_word();
        early_pulses = 0;
        early_seen   = 32'h0;
        start_refill(32'h2000_001C);
        drive_beats(32'h0000_0050, 0, 7);
        @(negedge aclk);
        sample_early();
        finish_resp();
        @(negedge aclk);
        sample_early();
`ifdef REFILL_EARLY_WORD_EN
        checks++;
        if (early_pulses !== 1 || early_seen !== 32'h0000_0057) begin
            errors++;
            $display("FAIL early_pulse: pulses=%0d data=%h, required 1 00000057", early_pulses, early_seen);
        end
`else
        checks++;
        if (early_pulses !== 0) begin
            errors++;
            $display("FAIL early_disabled: pulses=%0d, required 0", early_pulses);
        end
`endif
        checks++;
        if (resp_line !== mk_line(32'h0000_0050)) begin
            errors++;
            $display("FAIL early_line: got %h, required %h", resp_line, mk_line(32'h0000_0050));
        end
    endtask

    task automatic test_rlast_err();
        start_refill(32'h4000_0000);
        drive_beats(32'h0000_0060, 0, 2);
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_line !== mk_line(32'h0000_0060)) begin
            errors++;
            $display("FAIL rlast_err: valid=%b err=%b line=%h, required 1 1 %h",
                     resp_valid, resp_err, resp_line, mk_line(32'h0000_0060));
        end
        finish_resp();
        start_refill(32'h4000_0020);
        checks++;
        if (resp_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_on_accept: got %b, required 0", resp_err);
        end
        drive_beats(32'h0000_0070, 0, 7);
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_line !== mk_line(32'h0000_0070)) begin
            errors++;
            $display("FAIL clean_after_err: valid=%b err=%b line=%h, required 1 0 %h",
                     resp_valid, resp_err, resp_line, mk_line(32'h0000_0070));
        end
        finish_resp();
    endtask

    task automatic test_reset_mid_data();
        start_refill(32'h3000_0008);
        for (int i = 0; i < 4; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 32'hEE00_0000 + 32'(i);
            @(negedge aclk);
        end
        m_axi_rvalid = 1'b0;
        checks++;
        if (m_axi_rready !== 1'b1) begin
            errors++;
            $display("FAIL mid_data_rready: got %b, required 1", m_axi_rready);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if (m_axi_rready !== 1'b0 || m_axi_arvalid !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rready=%b arvalid=%b resp_valid=%b, required 0 0 0",
                     m_axi_rready, m_axi_arvalid, resp_valid);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        m_axi_rvalid = 1'b1;
        @(negedge aclk);
        m_axi_rvalid = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || m_axi_rready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: req_ready=%b rready=%b, required 1 0", req_ready, m_axi_rready);
        end
        start_refill(32'h3000_0008);
        checks++;
        if (m_axi_araddr !== 32'h3000_0000 || m_axi_rready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ar: araddr=%h rready=%b, required 30000000 1", m_axi_araddr, m_axi_rready);
        end
        drive_beats(32'h0000_0030, 0, 7);
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_line !== mk_line(32'h0000_0030)) begin
            errors++;
            $display("FAIL post_reset_refill: valid=%b err=%b line=%h, required 1 0 %h",
                     resp_valid, resp_err, resp_line, mk_line(32'h0000_0030));
        end
        finish_resp();
    endtask

    initial begin
        aresetn       = 1'b0;
        req_valid     = 1'b0;
        req_addr      = 32'h0;
        resp_ready    = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rdata   = 32'h0;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;
        early_pulses  = 0;
        early_seen    = 32'h0;

        test_reset();
        test_basic();
        test_backpressure();
        test_early_word();
        test_rlast_err();
        test_reset_mid_data();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_axi_refill_master
